prio_encoder_rr: RTL and testbench
==================================

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter WIDTH, default 32, SHALL set the request vector width, legal range 2..64.
REQ-003 Parameter CODE_W, default $clog2(WIDTH), SHALL set the code width.
REQ-004 Port clk  input  1  SHALL be the rising-edge clock.
REQ-005 Port rst_n  input  1  SHALL be the asynchronous reset, active low.
REQ-006 Port in_valid  input  1  SHALL mark a request vector as present.
REQ-007 Port in_ready  output  1  SHALL indicate the block can accept a vector.
REQ-008 Port in_data  input  WIDTH  SHALL carry the raw request bits.
REQ-009 Port in_mask  input  WIDTH  SHALL carry the mask bits; 1 = bit ignored.
REQ-010 Port in_mode  input  2  SHALL select the search mode: 00 MSB-first, 01 LSB-first, 10 round-robin, 11 treated as 00.
REQ-011 Port out_valid  output  1  SHALL mark a result as held.
REQ-012 Port out_ready  input  1  SHALL indicate the consumer takes the result.
REQ-013 Port out_code  output  CODE_W  SHALL carry the index of the selected bit.
REQ-014 Port out_onehot  output  WIDTH  SHALL carry the one-hot vector of the selected bit.
REQ-015 Port out_found  output  1  SHALL be 1 when any effective bit was set.

Function
REQ-016 Effective vector eff = in_data & ~in_mask, evaluated on the accept cycle only.
REQ-017 Accept SHALL occur when in_valid && in_ready; in_ready = !out_valid || out_ready (combinational, no dependency on in_valid).
REQ-018 Latency SHALL be 1 cycle: the result registers update on the accept edge, and out_valid is 1 the following cycle.
REQ-019 Result SHALL hold stable while out_valid && !out_ready.
REQ-020 Simultaneous drain and accept SHALL keep out_valid=1 and load the new result; no bubble.
REQ-021 When out_ready=1 and there is no accept, out_valid SHALL fall to 0 on the next edge.
REQ-022 Mode 00 SHALL select the highest set index of eff.
REQ-023 Mode 01 SHALL select the lowest set index of eff.
REQ-024 Mode 10 SHALL select the lowest set index >= ptr; if none exists, it SHALL select the lowest set index overall (wrap).
REQ-025 ptr (CODE_W bits) SHALL update only on an accept in mode 10 with out_found=1: ptr <= code+1, or 0 if code = WIDTH-1.
REQ-026 ptr SHALL remain unchanged on an accept in any other mode or when eff = 0.
REQ-027 eff = 0 SHALL give out_found=0, out_code=0, out_onehot=0, with out_valid still asserted.
REQ-028 out_onehot SHALL equal 1 << out_code whenever out_found=1.
REQ-029 For non-power-of-two WIDTH, codes >= WIDTH SHALL never be produced.
REQ-030 in_mode SHALL be sampled per accepted vector; a mode change between vectors SHALL take effect immediately.

Reset
REQ-031 On rst_n=0, asynchronously: out_valid=0, out_code=0, out_onehot=0, out_found=0, ptr=0.
REQ-032 in_ready SHALL be 1 during and after reset.
REQ-033 A reset with a result pending SHALL discard that result; the next accept SHALL behave as a first vector after reset.

Verification
REQ-034 MSB mode, WIDTH=32: in_data=0x0000_8421, mask=0 -> next cycle out_code=15, onehot=0x0000_8000, found=1.
REQ-035 LSB mode with masking: in_data=0x0000_8421, in_mask=0x0000_0001 -> out_code=5, found=1.
REQ-036 Round-robin: in_data=0x0000_0011 accepted three times -> codes 0, 4, 0, with ptr 1, 5, 1.
REQ-037 Wrap, WIDTH=24: ptr=23, in_data=0x80_0001 -> code 23, ptr=0; the next identical vector -> code 0.
REQ-038 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and out_code held; when out_ready=1, the new vector loads in the same cycle.
REQ-039 Zero vector, then rst_n pulsed mid-hold -> found=0 and code=0, then all outputs 0 and ptr=0 immediately on reset assertion.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Masked priority encoder (MSB-first, LSB-first, round-robin) feeding a
// single-entry registered valid/ready output stage with one cycle of latency.
module prio_encoder_rr #(
  parameter int WIDTH  = 32,
  parameter int CODE_W = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [WIDTH-1:0]  in_mask,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [WIDTH-1:0]  out_onehot,
  output logic              out_found
);

  localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]  ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  function automatic logic [CODE_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

  function automatic logic [CODE_W-1:0] highest_idx(input logic [WIDTH-1:0] v);
    logic [CODE_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = CODE_W'(i);
    end
    return r;
  endfunction

  logic              vld_p0;
  logic              found_p0;
  logic [CODE_W-1:0] code_p0;
  logic [WIDTH-1:0]  onehot_p0;
  logic [CODE_W-1:0] rr_ptr;

  logic              accept;
  logic              found;
  logic              mode_rr;
  logic [WIDTH-1:0]  eff;
  logic [WIDTH-1:0]  eff_hi;
  logic [CODE_W-1:0] sel_code;
  logic [WIDTH-1:0]  sel_onehot;

  assign in_ready = !vld_p0 || out_ready;
  assign accept   = in_valid && in_ready;
  assign eff      = in_data & ~in_mask;
  assign found    = |eff;
  assign mode_rr  = (in_mode == 2'b10);

  always_comb begin
    eff_hi     = '0;
    sel_code   = '0;
    sel_onehot = '0;
    for (int i = 0; i < WIDTH; i++) begin
      eff_hi[i] = eff[i] && (i >= int'(rr_ptr));
    end
    case (in_mode)
      2'b01:   sel_code = lowest_idx(eff);
      // Round-robin: first set bit at or above the pointer, else wrap to the lowest.
      2'b10:   sel_code = (|eff_hi) ? lowest_idx(eff_hi) : lowest_idx(eff);
      default: sel_code = highest_idx(eff);
    endcase
    if (found) sel_onehot = ONE_HOT0 << sel_code;
  end

  // Stage p0: result register, loaded on accept, held under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      found_p0  <= 1'b0;
      code_p0   <= '0;
      onehot_p0 <= '0;
      rr_ptr    <= '0;
    end else if (accept) begin
      vld_p0    <= 1'b1;
      found_p0  <= found;
      code_p0   <= sel_code;
      onehot_p0 <= sel_onehot;
      if (mode_rr && found) begin
        rr_ptr <= (sel_code == LAST_IDX) ? '0 : sel_code + CODE_W'(1);
      end
    end else if (out_ready) begin
      vld_p0 <= 1'b0;
    end
  end

  assign out_valid  = vld_p0;
  assign out_found  = found_p0;
  assign out_code   = code_p0;
  assign out_onehot = onehot_p0;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Scoreboard bench for prio_encoder_rr: a 32-bit and a 24-bit instance driven
// with directed vectors whose expected codes are written out by hand.
module tb_prio_encoder_rr;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_found;
  logic [31:0] a_in_data, a_in_mask, a_out_onehot;
  logic [1:0]  a_in_mode;
  logic [4:0]  a_out_code;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_found;
  logic [23:0] b_in_data, b_in_mask, b_out_onehot;
  logic [1:0]  b_in_mode;
  logic [4:0]  b_out_code;

  typedef struct packed {
    logic        found;
    logic [4:0]  code;
    logic [31:0] onehot;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  int total;
  int passed;

  prio_encoder_rr #(.WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_mask(a_in_mask), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_code(a_out_code), .out_onehot(a_out_onehot), .out_found(a_out_found)
  );

  prio_encoder_rr #(.WIDTH(24)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_mask(b_in_mask), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_code(b_out_code), .out_onehot(b_out_onehot), .out_found(b_out_found)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  function automatic exp_t mk(input logic f, input logic [4:0] c);
    exp_t e;
    e.found  = f;
    e.code   = c;
    e.onehot = f ? (32'd1 << c) : 32'd0;
    return e;
  endfunction

  // Monitor: every output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        check("a_unexpected_output", 64'(a_out_valid), 64'(0));
      end else begin
        ea = qa.pop_front();
        check("a_found",  64'(a_out_found),  64'(ea.found));
        check("a_code",   64'(a_out_code),   64'(ea.code));
        check("a_onehot", 64'(a_out_onehot), 64'(ea.onehot));
      end
    end
    if (rst_n && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        check("b_unexpected_output", 64'(b_out_valid), 64'(0));
      end else begin
        eb = qb.pop_front();
        check("b_found",  64'(b_out_found),  64'(eb.found));
        check("b_code",   64'(b_out_code),   64'(eb.code));
        check("b_onehot", 64'(b_out_onehot), 64'(eb.onehot));
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic [31:0] m, input logic [1:0] md,
                        input logic f, input logic [4:0] c);
    int n;
    a_in_data = d; a_in_mask = m; a_in_mode = md; a_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!a_in_ready) check("a_accept_timeout", 64'(a_in_ready), 64'(1));
    else qa.push_back(mk(f, c));
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_data = 32'hFFFF_FFFF; a_in_mask = 32'h0; a_in_mode = 2'b00;
  endtask

  task automatic send_b(input logic [23:0] d, input logic [23:0] m, input logic [1:0] md,
                        input logic f, input logic [4:0] c);
    int n;
    b_in_data = d; b_in_mask = m; b_in_mode = md; b_in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_in_ready && n < 50) begin n++; @(negedge clk); end
    if (!b_in_ready) check("b_accept_timeout", 64'(b_in_ready), 64'(1));
    else qb.push_back(mk(f, c));
    @(posedge clk); #1;
    b_in_valid = 1'b0; b_in_data = 24'hFF_FFFF; b_in_mask = 24'h0; b_in_mode = 2'b00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    total = 0; passed = 0;
    rst_n = 1'b1;
    a_in_valid = 0; a_in_data = 0; a_in_mask = 0; a_in_mode = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = 0; b_in_mask = 0; b_in_mode = 0; b_out_ready = 1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid",  64'(a_out_valid),  64'(0));
    check("rst_out_code",   64'(a_out_code),   64'(0));
    check("rst_out_onehot", 64'(a_out_onehot), 64'(0));
    check("rst_out_found",  64'(a_out_found),  64'(0));
    check("rst_in_ready",   64'(a_in_ready),   64'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 64'(a_in_ready), 64'(1));

    // Mode coverage, back-to-back accepts with the consumer always ready.
    send_a(32'h0000_8421, 32'h0, 2'b00, 1, 5'd15);
    send_a(32'h0000_8421, 32'h1, 2'b01, 1, 5'd5);
    send_a(32'h0000_8421, 32'h0, 2'b11, 1, 5'd15);
    send_a(32'h0000_8421, 32'h0000_8421, 2'b01, 0, 5'd0);
    send_a(32'h0000_0011, 32'h0, 2'b10, 1, 5'd0);
    send_a(32'h0000_0011, 32'h0, 2'b10, 1, 5'd4);
    send_a(32'h0000_0011, 32'h0, 2'b10, 1, 5'd0);
    send_a(32'h8000_0001, 32'h0, 2'b00, 1, 5'd31);
    send_a(32'h0000_0003, 32'h0, 2'b10, 1, 5'd1);
    send_a(32'h0000_0000, 32'h0, 2'b10, 0, 5'd0);
    send_a(32'h0000_0005, 32'h0, 2'b10, 1, 5'd2);
    send_a(32'h8000_0000, 32'h0, 2'b10, 1, 5'd31);
    send_a(32'h8000_0001, 32'h0, 2'b10, 1, 5'd0);

    // Backpressure: result held, input stalled, then drain and load in one edge.
    repeat (3) @(posedge clk); #1;
    a_out_ready = 1'b0;
    send_a(32'h0000_8421, 32'h0, 2'b00, 1, 5'd15);
    a_in_data = 32'h0000_8421; a_in_mask = 32'h0; a_in_mode = 2'b01; a_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready_low", 64'(a_in_ready),   64'(0));
      check("bp_valid_held",   64'(a_out_valid),  64'(1));
      check("bp_code_held",    64'(a_out_code),   64'(15));
      check("bp_onehot_held",  64'(a_out_onehot), 64'(32'h0000_8000));
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 64'(a_in_ready), 64'(1));
    if (a_in_ready) qa.push_back(mk(1, 5'd0));
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    check("bp_no_bubble", 64'(a_out_valid), 64'(1));
    check("bp_new_code",  64'(a_out_code),  64'(0));
    @(posedge clk); #1;
    check("drain_valid_low", 64'(a_out_valid), 64'(0));

    // 24-bit instance: pointer wrap at the top index, no out-of-range codes.
    send_b(24'h40_0000, 24'h0, 2'b10, 1, 5'd22);
    send_b(24'h80_0001, 24'h0, 2'b10, 1, 5'd23);
    send_b(24'h80_0001, 24'h0, 2'b10, 1, 5'd0);
    send_b(24'h80_0001, 24'h0, 2'b10, 1, 5'd23);
    send_b(24'hFF_FFFF, 24'h0, 2'b00, 1, 5'd23);
    send_b(24'h80_0000, 24'h0, 2'b01, 1, 5'd23);
    repeat (3) @(posedge clk); #1;

    // Pointer moved to 5, then a zero vector held and discarded by reset.
    send_a(32'h0000_0010, 32'h0, 2'b10, 1, 5'd4);
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    send_a(32'h0000_0000, 32'h0, 2'b01, 0, 5'd0);
    check("zero_valid",  64'(a_out_valid),  64'(1));
    check("zero_found",  64'(a_out_found),  64'(0));
    check("zero_code",   64'(a_out_code),   64'(0));
    check("zero_onehot", 64'(a_out_onehot), 64'(0));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid",    64'(a_out_valid),  64'(0));
    check("midrst_code",     64'(a_out_code),   64'(0));
    check("midrst_onehot",   64'(a_out_onehot), 64'(0));
    check("midrst_found",    64'(a_out_found),  64'(0));
    check("midrst_in_ready", 64'(a_in_ready),   64'(1));
    qa.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    send_a(32'h0000_0030, 32'h0, 2'b10, 1, 5'd4);

    repeat (4) @(posedge clk); #1;
    check("a_queue_drained", 64'(qa.size()), 64'(0));
    check("b_queue_drained", 64'(qb.size()), 64'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
